// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI bus configuration, channel structs and arbiter helpers.
//   obi_cfg_t           bus feature switches (UseRReady honoured; atop/integrity unsupported)
//   obi_req_t/obi_rsp_t default manager->subordinate / subordinate->manager structs
//   obi_arb_idx_width   width of a manager index (at least 1 bit)
//   obi_arb_state_e     arbiter lock state
package obi_pkg;

  typedef struct packed {
    logic UseRReady;
    logic UseAtop;
    logic Integrity;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{UseRReady: 1'b0, UseAtop: 1'b0, Integrity: 1'b0};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_rsp_t;

  function automatic int unsigned obi_arb_idx_width(input int unsigned num_mgr);
    return (num_mgr <= 1) ? 1 : $clog2(num_mgr);
  endfunction

  typedef enum logic {ARB_IDLE, ARB_HOLD} obi_arb_state_e;

endpackage

// File: rtl/obi_arb_idx_fifo.sv
// obi_arb_idx_fifo: in-order FIFO of granted manager indices (no fall-through).
//   i_clk/i_rst   clock, synchronous active-high reset
//   i_push/i_data write an index (ignored when full)
//   i_pop         drop the head entry (ignored when empty)
//   o_full/o_empty/o_head/o_count  registered status and head entry
module obi_arb_idx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [Width-1:0]             i_data,
  input  logic                         i_pop,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [Width-1:0]             o_head,
  output logic [$clog2(Depth+1)-1:0]   o_count
);
  import obi_pkg::*;

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth <= 1) ? 1 : $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (@(posedge i_clk) disable iff (i_rst) !(i_pop && o_empty))
    else $error("idx fifo popped while empty");
  a_count_bound: assert property (@(posedge i_clk) r_count <= CntW'(Depth))
    else $error("idx fifo count exceeds depth");
`endif

endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin share of one OBI subordinate among NumMgr managers.
//   clk_i/rst_i  clock, synchronous active-high reset
//   mgr_req_i    manager requests          mgr_rsp_o  per-manager gnt/rvalid/r
//   sbr_req_o    request to subordinate    sbr_rsp_i  subordinate gnt/rvalid/r
//   busy_o       transactions outstanding or a request is locked awaiting gnt
// A-channel and R-channel paths are combinational; granted indices are queued so
// responses return to their issuer in order.
module obi_rr_arbiter #(
  parameter obi_pkg::obi_cfg_t ObiCfg = obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = obi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_pkg::obi_rsp_t,
  parameter int unsigned NumMgr   = 2,
  parameter int unsigned MaxTrans = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t sbr_req_o,
  input  obi_rsp_t sbr_rsp_i,
  output logic     busy_o
);
  import obi_pkg::*;

  localparam int unsigned IdxW = obi_arb_idx_width(NumMgr);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  obi_arb_state_e  r_state;
  obi_arb_state_e  w_state_nxt;
  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] w_rr_sel;
  logic [IdxW-1:0] w_cand;
  logic            w_rr_hit;
  logic [IdxW-1:0] w_sel;
  logic [IdxW-1:0] w_ptr_nxt;
  logic [IdxW-1:0] w_head;
  logic [CntW-1:0] w_count;
  logic            w_fifo_full;
  logic            w_full;
  logic            w_empty;
  logic            w_sreq;
  logic            w_hs;
  logic            w_rready;
  logic            w_pop;

  // First requester at or after r_rr_ptr, wrapping modulo NumMgr.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_rr_hit = 1'b0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NumMgr; k++) begin
      w_cand = IdxW'((32'(r_rr_ptr) + k) % NumMgr);
      if (!w_rr_hit && mgr_req_i[w_cand].req) begin
        w_rr_sel = w_cand;
        w_rr_hit = 1'b1;
      end
    end
  end

  // Full comes from the registered count only, so a same-cycle pop never frees a push slot.
  assign w_full    = (w_count == CntW'(MaxTrans));
  assign w_sel     = (r_state == ARB_HOLD) ? r_lock_idx : w_rr_sel;
  assign w_sreq    = mgr_req_i[w_sel].req & ~w_full & ~rst_i;
  assign w_hs      = w_sreq & sbr_rsp_i.gnt;
  assign w_ptr_nxt = (w_sel == IdxW'(NumMgr - 1)) ? '0 : w_sel + IdxW'(1);
  assign w_rready  = ObiCfg.UseRReady ? mgr_req_i[w_head].rready : 1'b1;
  assign w_pop     = sbr_rsp_i.rvalid & w_rready & ~rst_i;
  assign busy_o    = ~rst_i & ((w_count != '0) | (r_state == ARB_HOLD));

  always_comb begin
    sbr_req_o        = mgr_req_i[w_sel];
    sbr_req_o.req    = w_sreq;
    sbr_req_o.rready = w_rready;
  end

  // Grant goes to the selected manager; rvalid/r only to the FIFO head, dropped when empty.
  always_comb begin
    for (int unsigned m = 0; m < NumMgr; m++) begin
      mgr_rsp_o[m] = '0;
      if (IdxW'(m) == w_sel) begin
        mgr_rsp_o[m].gnt = sbr_rsp_i.gnt & ~w_full & ~rst_i;
      end
      if ((IdxW'(m) == w_head) && !w_empty && !rst_i) begin
        mgr_rsp_o[m].rvalid = sbr_rsp_i.rvalid;
        mgr_rsp_o[m].r      = sbr_rsp_i.r;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_sreq && !sbr_rsp_i.gnt) w_state_nxt = ARB_HOLD;
      ARB_HOLD: if (w_hs) w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_rr_ptr <= w_ptr_nxt;
      if ((r_state == ARB_IDLE) && w_sreq && !sbr_rsp_i.gnt) r_lock_idx <= w_sel;
    end
  end

  obi_arb_idx_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_idx_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_hs),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_full  (w_fifo_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (w_count)
  );

`ifndef SYNTHESIS
  a_a_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (sbr_req_o.req && !sbr_rsp_i.gnt) |=> (sbr_req_o.req && $stable(sbr_req_o.a)))
    else $error("A-channel changed before grant");
  a_rvalid_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    !(sbr_rsp_i.rvalid && w_empty))
    else $error("rvalid with no outstanding transaction");
  a_full_flag: assert property (@(posedge clk_i) w_fifo_full == w_full)
    else $error("full flag disagreement");
`endif

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;
  import obi_pkg::*;

  localparam int unsigned NM = 2;
  localparam int unsigned MT = 3;
  localparam obi_cfg_t Cfg = '{UseRReady: 1'b1, UseAtop: 1'b0, Integrity: 1'b0};

  typedef struct {
    int          mgr;
    obi_r_chan_t r;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst;
  obi_req_t mgr_req [NM];
  obi_rsp_t mgr_rsp [NM];
  obi_req_t sbr_req;
  obi_rsp_t sbr_rsp;
  logic     busy;

  int nchk = 0;
  int nerr = 0;
  int req_pct, gnt_pct, rv_pct, rdy_pct;
  bit gen_random;

  obi_a_chan_t dq [NM][$];
  obi_a_chan_t cur [NM];
  bit          issued [NM];
  exp_t        exp_q[$];
  int          inflight[$];
  obi_r_chan_t sub_q[$];
  bit          sub_presenting;
  int          m_ptr, m_lock;
  bit          m_hold;
  logic [31:0] ref_mem [16];
  logic [31:0] sim_mem [16];

  obi_rr_arbiter #(
    .ObiCfg    (Cfg),
    .obi_req_t (obi_req_t),
    .obi_rsp_t (obi_rsp_t),
    .NumMgr    (NM),
    .MaxTrans  (MT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .mgr_req_i (mgr_req),
    .mgr_rsp_o (mgr_rsp),
    .sbr_req_o (sbr_req),
    .sbr_rsp_i (sbr_rsp),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic obi_a_chan_t mk_txn(input logic [31:0] addr, input logic we,
                                         input logic [31:0] wdata, input logic [3:0] aid);
    obi_a_chan_t t;
    t.addr  = addr;
    t.we    = we;
    t.be    = 4'hF;
    t.wdata = wdata;
    t.aid   = aid;
    return t;
  endfunction

  function automatic obi_a_chan_t rand_txn();
    logic [3:0] w;
    w = 4'($urandom_range(15));
    return mk_txn({26'd0, w, 2'b00}, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)));
  endfunction

  // Memory behaviour: writes return rdata 0; rid echoes aid; err flags the upper half.
  function automatic obi_r_chan_t mem_resp(input obi_a_chan_t a, input logic [31:0] rd);
    obi_r_chan_t r;
    r.rdata = a.we ? 32'd0 : rd;
    r.rid   = a.aid;
    r.err   = a.addr[5];
    return r;
  endfunction

  // Stimulus: managers and subordinate drive just after the rising edge.
  always @(posedge clk) begin
    #1;
    for (int m = 0; m < NM; m++) begin
      if (!issued[m]) begin
        if (dq[m].size() > 0) begin
          cur[m] = dq[m].pop_front();
          issued[m] = 1'b1;
        end else if (gen_random && ($urandom_range(99) < req_pct)) begin
          cur[m] = rand_txn();
          issued[m] = 1'b1;
        end
      end
      mgr_req[m].req    = issued[m];
      mgr_req[m].a      = cur[m];
      mgr_req[m].rready = ($urandom_range(99) < rdy_pct);
    end
    sbr_rsp.gnt = ($urandom_range(99) < gnt_pct);
    if (!sub_presenting && (sub_q.size() > 0) && ($urandom_range(99) < rv_pct)) sub_presenting = 1'b1;
    sbr_rsp.rvalid = sub_presenting;
    sbr_rsp.r      = sub_presenting ? sub_q[0] : '0;
  end

  // Reference arbiter model plus the memory-side subordinate.
  always @(negedge clk) begin
    if (rst) begin
      chk(sbr_req.req == 1'b0, "rst_sreq", 64'(sbr_req.req), 0);
      for (int m = 0; m < NM; m++) begin
        chk(mgr_rsp[m].gnt == 1'b0, "rst_gnt", 64'(mgr_rsp[m].gnt), 0);
        chk(mgr_rsp[m].rvalid == 1'b0, "rst_rvalid", 64'(mgr_rsp[m].rvalid), 0);
        issued[m] = 1'b0;
      end
      chk(busy == 1'b0, "rst_busy", 64'(busy), 0);
      m_ptr = 0; m_hold = 1'b0; m_lock = 0;
      inflight.delete();
      sub_q.delete();
      sub_presenting = 1'b0;
    end else begin
      bit full, exp_sreq, hs;
      int sel;
      full = (inflight.size() == MT);
      chk(busy == ((inflight.size() != 0) || m_hold), "busy", 64'(busy),
          64'((inflight.size() != 0) || m_hold));
      sel = -1;
      if (m_hold) sel = m_lock;
      else
        for (int k = 0; k < NM; k++)
          if (sel < 0 && mgr_req[(m_ptr + k) % NM].req) sel = (m_ptr + k) % NM;
      exp_sreq = (sel >= 0) && mgr_req[sel].req && !full;
      chk(sbr_req.req == exp_sreq, "sbr_req", 64'(sbr_req.req), 64'(exp_sreq));
      if (exp_sreq) chk(sbr_req.a == cur[sel], "a_route", sbr_req.a.addr, cur[sel].addr);
      for (int m = 0; m < NM; m++)
        if (mgr_req[m].req)
          chk(mgr_rsp[m].gnt == ((m == sel) && exp_sreq && sbr_rsp.gnt), "gnt",
              64'(mgr_rsp[m].gnt), 64'((m == sel) && exp_sreq && sbr_rsp.gnt));
      if (inflight.size() > 0)
        chk(sbr_req.rready == mgr_req[inflight[0]].rready, "rready_route",
            64'(sbr_req.rready), 64'(mgr_req[inflight[0]].rready));
      if (sbr_rsp.rvalid && (inflight.size() > 0) && mgr_req[inflight[0]].rready)
        void'(inflight.pop_front());
      hs = exp_sreq && sbr_rsp.gnt;
      if (hs) begin
        exp_q.push_back('{mgr: sel, r: mem_resp(cur[sel], ref_mem[cur[sel].addr[5:2]])});
        if (cur[sel].we) ref_mem[cur[sel].addr[5:2]] = cur[sel].wdata;
        inflight.push_back(sel);
        m_ptr  = (sel + 1) % NM;
        m_hold = 1'b0;
      end else if (exp_sreq) begin
        m_hold = 1'b1;
        m_lock = sel;
      end
      for (int m = 0; m < NM; m++)
        if (issued[m] && mgr_rsp[m].gnt) issued[m] = 1'b0;
      if (sbr_rsp.rvalid && sbr_req.rready) begin
        if (sub_q.size() > 0) void'(sub_q.pop_front());
        sub_presenting = 1'b0;
      end
      if (sbr_req.req && sbr_rsp.gnt) begin
        sub_q.push_back(mem_resp(sbr_req.a, sim_mem[sbr_req.a.addr[5:2]]));
        if (sbr_req.a.we) sim_mem[sbr_req.a.addr[5:2]] = sbr_req.a.wdata;
      end
    end
  end

  // Monitor: every manager-side rvalid is matched against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      int nv, who;
      nv = 0; who = -1;
      for (int m = 0; m < NM; m++)
        if (mgr_rsp[m].rvalid) begin nv++; who = m; end
      if (sbr_rsp.rvalid) begin
        chk(nv == 1, "rvalid_onehot", 64'(nv), 1);
        if (nv == 1) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "rvalid_unexpected", 64'(who), 0);
          end else begin
            chk(who == exp_q[0].mgr, "r_dest", 64'(who), 64'(exp_q[0].mgr));
            chk(mgr_rsp[who].r == exp_q[0].r, "r_data", 64'(mgr_rsp[who].r), 64'(exp_q[0].r));
            for (int m = 0; m < NM; m++)
              if (m != who) chk(mgr_rsp[m].r == '0, "r_other_zero", 64'(mgr_rsp[m].r), 0);
            if (mgr_req[who].rready) void'(exp_q.pop_front());
          end
        end
      end else begin
        chk(nv == 0, "rvalid_spurious", 64'(nv), 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(posedge clk);
      idle = (exp_q.size() == 0) && (dq[0].size() == 0) && (dq[1].size() == 0) &&
             !issued[0] && !issued[1];
    end
    #1;
    chk(idle, nm, 64'(exp_q.size()), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sub_presenting = 1'b0;
    m_ptr = 0; m_hold = 1'b0; m_lock = 0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; sim_mem[i] = '0; end
    for (int m = 0; m < NM; m++) begin
      issued[m] = 1'b0;
      cur[m] = '0;
      mgr_req[m] = '0;
    end
    sbr_rsp = '0;
    // Requests active during reset must stay invisible.
    gen_random = 1'b1; req_pct = 100; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
    cyc(4);
    rst = 1'b0;
    cyc(40);                                  // saturated alternation
    gnt_pct = 25;            cyc(60);         // slow grant, lock held
    gnt_pct = 100; rv_pct = 0; cyc(15);       // no responses: fills to MaxTrans
    rv_pct = 70; rdy_pct = 30; cyc(100);      // manager rready backpressure
    req_pct = 60; gnt_pct = 60; rv_pct = 60; rdy_pct = 60; cyc(800);
    // Reset while locked with outstanding transactions.
    req_pct = 100; gnt_pct = 100; rv_pct = 0; rdy_pct = 100; cyc(2);
    gnt_pct = 0; cyc(3);
    rst = 1'b1; cyc(1);
    rst = 1'b0;
    gnt_pct = 100; rv_pct = 100; cyc(30);
    // Write/read-back by two managers.
    gen_random = 1'b0;
    wait_idle("idle_before_rw");
    rdy_pct = 100; gnt_pct = 70; rv_pct = 80;
    dq[0].push_back(mk_txn(32'h0, 1'b1, 32'hDEADBEEF, 4'h3));
    dq[1].push_back(mk_txn(32'h4, 1'b1, 32'h12345678, 4'h9));
    dq[0].push_back(mk_txn(32'h0, 1'b0, 32'h0, 4'h5));
    dq[1].push_back(mk_txn(32'h4, 1'b0, 32'h0, 4'hA));
    wait_idle("drain_rw");
    chk(ref_mem[0] == 32'hDEADBEEF, "rw_m0_word", 64'(ref_mem[0]), 64'h0DEADBEEF);
    chk(sim_mem[1] == 32'h12345678, "rw_m1_word", 64'(sim_mem[1]), 64'h12345678);
    gen_random = 1'b1; req_pct = 50; gnt_pct = 50; rv_pct = 50; rdy_pct = 50; cyc(300);
    gen_random = 1'b0;
    wait_idle("final_drain");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
